// File: rtl/piezo_arbiter_pkg.sv
// Shared types for the piezo arbiter: FSM state encoding, source codes on the src port,
// and helpers used to size timing parameters.
package piezo_arbiter_pkg;

    typedef enum logic [2:0] {
        ENGINE   = 3'd0,
        CHIRP    = 3'd1,
        WARN_ON  = 3'd2,
        WARN_OFF = 3'd3,
        GAP      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SRC_ENGINE = 2'd0,
        SRC_CHIRP  = 2'd1,
        SRC_WARN   = 2'd2,
        SRC_GAP    = 2'd3
    } src_t;

    function automatic int ms_to_cyc(input int ms, input int clk_hz);
        return (ms * clk_hz) / 1000;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Both warning phases report as the warning source.
    function automatic src_t src_of(input state_t st);
        case (st)
            ENGINE:   return SRC_ENGINE;
            CHIRP:    return SRC_CHIRP;
            WARN_ON:  return SRC_WARN;
            WARN_OFF: return SRC_WARN;
            GAP:      return SRC_GAP;
            default:  return SRC_ENGINE;
        endcase
    endfunction

endpackage

// File: rtl/piezo_arbiter_if.sv
// Sound-source inputs and piezo/status outputs of the arbiter, grouped as one bundle.
interface piezo_arbiter_if;

    logic       engine_in;
    logic       engine_en;
    logic [2:0] gear;
    logic       redline;
    logic       piezo;
    logic [1:0] src;
    logic       busy;

    modport master (
        output engine_in,
        output engine_en,
        output gear,
        output redline,
        input  piezo,
        input  src,
        input  busy
    );

    modport slave (
        input  engine_in,
        input  engine_en,
        input  gear,
        input  redline,
        output piezo,
        output src,
        output busy
    );

endinterface

// File: rtl/piezo_arbiter_tone_gen.sv
// Square-wave generator with a programmable half period; tone is the level for the
// coming cycle so the caller can register it on the same edge as its state change.
module piezo_arbiter_tone_gen #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] half,
    output logic         tone
);

    logic [W-1:0] cnt;
    logic         lvl;
    logic         wrap;

    assign wrap = (cnt == half - W'(1));

    // A clear restarts the wave on a high level so every beep begins identically.
    always_comb begin
        tone = lvl;
        if (clr) begin
            tone = 1'b1;
        end else if (wrap) begin
            tone = ~lvl;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            lvl <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            lvl <= 1'b1;
        end else if (wrap) begin
            cnt <= '0;
            lvl <= ~lvl;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/piezo_arbiter.sv
// Arbitrates the single piezo between engine tone, gear-shift chirp and pulsed redline
// warning, inserting silent gaps so the driver never hears a glitched transition.
module piezo_arbiter
    import piezo_arbiter_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 10_000,
    parameter int CHIRP_HALF  = 10,
    parameter int WARN_HALF   = 4,
    parameter int CHIRP_CYC   = ms_to_cyc(80, CLK_FREQ_HZ),
    parameter int WARN_CYC    = ms_to_cyc(100, CLK_FREQ_HZ),
    parameter int GAP_CYC     = ms_to_cyc(20, CLK_FREQ_HZ)
) (
    input  logic            clk,
    input  logic            rst,
    piezo_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(max3(CHIRP_CYC, WARN_CYC, GAP_CYC)) + 1;

    localparam logic [CNT_W-1:0] CHIRP_LAST = CNT_W'(CHIRP_CYC - 1);
    localparam logic [CNT_W-1:0] WARN_LAST  = CNT_W'(WARN_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] dur_cnt;
    logic [CNT_W-1:0] dur_next;
    logic             pending;
    logic             next_pending;
    logic             restart;
    logic [2:0]       gear_q;
    logic             primed;
    logic             gear_change;
    logic             tone_clr;
    logic [CNT_W-1:0] tone_half;
    logic             tone;
    logic             piezo_next;
    logic             piezo_q;
    src_t             src_q;
    logic             busy_q;

    // The first cycle out of reset only captures the gear, so a stale gear_q never chirps.
    assign gear_change = primed && (bus.gear != gear_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ENGINE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        next_pending = pending;
        restart      = 1'b0;
        case (state)
            ENGINE: begin
                if (bus.redline) begin
                    next_state = WARN_ON;
                    if (gear_change) next_pending = 1'b1;
                end else if (gear_change) begin
                    next_state = CHIRP;
                end
            end
            CHIRP: begin
                if (bus.redline) begin
                    next_state   = WARN_ON;
                    next_pending = 1'b0;
                end else if (gear_change) begin
                    restart = 1'b1;
                end else if (dur_cnt == CHIRP_LAST) begin
                    next_state = GAP;
                end
            end
            WARN_ON, WARN_OFF: begin
                if (gear_change) next_pending = 1'b1;
                // A phase always runs to completion; redline is only consulted at its end.
                if (dur_cnt == WARN_LAST) begin
                    if (bus.redline) begin
                        next_state = (state == WARN_ON) ? WARN_OFF : WARN_ON;
                    end else if (pending || gear_change) begin
                        next_state   = CHIRP;
                        next_pending = 1'b0;
                    end else begin
                        next_state = GAP;
                    end
                end
            end
            GAP: begin
                if (bus.redline) begin
                    next_state = WARN_ON;
                    if (gear_change) next_pending = 1'b1;
                end else if (gear_change || pending) begin
                    next_state   = CHIRP;
                    next_pending = 1'b0;
                end else if (dur_cnt == GAP_LAST) begin
                    next_state = ENGINE;
                end
            end
            default: begin
                next_state   = ENGINE;
                next_pending = 1'b0;
            end
        endcase
    end

    always_comb begin
        dur_next = '0;
        if ((next_state == state) && !restart && (state != ENGINE)) begin
            dur_next = dur_cnt + CNT_W'(1);
        end
    end

    assign tone_clr  = (next_state != state);
    assign tone_half = (next_state == CHIRP) ? CNT_W'(CHIRP_HALF) : CNT_W'(WARN_HALF);

    piezo_arbiter_tone_gen #(
        .W (CNT_W)
    ) u_tone_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (tone_clr),
        .half (tone_half),
        .tone (tone)
    );

    always_comb begin
        piezo_next = 1'b0;
        case (next_state)
            ENGINE:  piezo_next = bus.engine_in & bus.engine_en;
            CHIRP:   piezo_next = tone;
            WARN_ON: piezo_next = tone;
            default: piezo_next = 1'b0;
        endcase
    end

    // Outputs are registered from next-state values so they move on the same edge as state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dur_cnt <= '0;
            pending <= 1'b0;
            gear_q  <= '0;
            primed  <= 1'b0;
            piezo_q <= 1'b0;
            src_q   <= SRC_ENGINE;
            busy_q  <= 1'b0;
        end else begin
            dur_cnt <= dur_next;
            pending <= next_pending;
            gear_q  <= bus.gear;
            primed  <= 1'b1;
            piezo_q <= piezo_next;
            src_q   <= src_of(next_state);
            busy_q  <= (next_state != ENGINE);
        end
    end

    assign bus.piezo = piezo_q;
    assign bus.src   = src_q;
    assign bus.busy  = busy_q;

endmodule
